// File: rtl/pixel_sink_if.sv
// Pixel stream, framebuffer write port and clear control for pixel_sink.
// Pure wiring: no logic, no added latency.
// The master side offers pixels and may stall the framebuffer; the slave side is the sink.
interface pixel_sink_if #(
    parameter int COLOR_W = 1,
    parameter int ADDR_W  = 19
) ();
    // Pixel stream (valid/ready)
    logic               pix_valid;
    logic               pix_ready;
    logic [10:0]        pix_x;
    logic [10:0]        pix_y;
    logic [COLOR_W-1:0] pix_color;

    // Clear control and status
    logic               clear_req;
    logic               clear_busy;
    logic               clear_done;
    logic [15:0]        clip_cnt;

    // Framebuffer write port
    logic               fb_stall;
    logic               fb_we;
    logic [ADDR_W-1:0]  fb_addr;
    logic [COLOR_W-1:0] fb_wdata;

    modport master (
        output pix_valid, pix_x, pix_y, pix_color, clear_req, fb_stall,
        input  pix_ready, clear_busy, clear_done, clip_cnt, fb_we, fb_addr, fb_wdata
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color, clear_req, fb_stall,
        output pix_ready, clear_busy, clear_done, clip_cnt, fb_we, fb_addr, fb_wdata
    );
endinterface

// File: rtl/pixel_sink.sv
// Buffers (x,y,color) pixels, clips off-screen ones and writes y*WIDTH+x to the framebuffer; sweeps a clear on request.
// Latency: pixel accepted at edge k with empty FIFO and free output register is written (fb_we=1) after edge k+1.
// Backpressure: pix_ready drops when the FIFO is full or a clear is pending; fb_stall freezes the output register.
module pixel_sink #(
    parameter int               WIDTH       = 640,
    parameter int               HEIGHT      = 480,
    parameter int               FIFO_DEPTH  = 8,
    parameter int               ADDR_W      = 19,
    parameter int               COLOR_W     = 1,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
    input  logic         clk,
    input  logic         reset,
    pixel_sink_if.slave  sink_io
);
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    localparam logic [10:0]       WIDTH_C   = 11'(WIDTH);
    localparam logic [10:0]       HEIGHT_C  = 11'(HEIGHT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef struct packed {
        logic [10:0]        x;
        logic [10:0]        y;
        logic [COLOR_W-1:0] color;
    } pix_t;

    pix_t mem_q [FIFO_DEPTH];

    logic [PW:0]         wr_ptr_q, wr_ptr_d;
    logic [PW:0]         rd_ptr_q, rd_ptr_d;
    logic [1:0]          state_q, state_d;
    logic                fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]   fb_addr_q, fb_addr_d;
    logic [COLOR_W-1:0]  fb_wdata_q, fb_wdata_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    logic                clear_busy_q, clear_busy_d;
    logic                clear_done_q, clear_done_d;
    logic [15:0]         clip_cnt_q, clip_cnt_d;

    logic   fifo_empty, fifo_full;
    logic   pix_ready;
    logic   push, pop;
    logic   consumed, out_free;
    logic   on_screen;
    pix_t   head;
    logic [21:0] prod;
    logic   unused_prod_hi;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

    // Reset is folded in so the sink never advertises ready while being reset.
    assign pix_ready = reset && (state_q == S_RUN) && !fifo_full;
    assign push      = sink_io.pix_valid && pix_ready;

    // The register is free to reload when it is empty or its write leaves this edge.
    assign consumed = fb_we_q && !sink_io.fb_stall;
    assign out_free = !fb_we_q || !sink_io.fb_stall;
    assign pop      = !fifo_empty && out_free;

    assign head      = mem_q[rd_ptr_q[PW-1:0]];
    assign on_screen = (head.x < WIDTH_C) && (head.y < HEIGHT_C);
    assign prod      = 22'(head.y) * 22'(WIDTH) + 22'(head.x);
    assign unused_prod_hi = ^prod[21:ADDR_W];

    // Next-state for FIFO pointers, output register, sweep counter, clip counter and FSM.
    always_comb begin
        wr_ptr_d     = wr_ptr_q + (PW+1)'(push);
        rd_ptr_d     = rd_ptr_q + (PW+1)'(pop);
        state_d      = state_q;
        fb_we_d      = fb_we_q;
        fb_addr_d    = fb_addr_q;
        fb_wdata_d   = fb_wdata_q;
        sweep_d      = sweep_q;
        clear_busy_d = clear_busy_q;
        clear_done_d = 1'b0;
        clip_cnt_d   = clip_cnt_q;

        if (state_q == S_CLEAR) begin
            // The FIFO is empty here: no pushes are accepted outside S_RUN.
            if (consumed && (fb_addr_q == LAST_ADDR)) begin
                fb_we_d      = 1'b0;
                sweep_d      = '0;
                state_d      = S_RUN;
                clear_busy_d = 1'b0;
                clear_done_d = 1'b1;
            end else if (out_free) begin
                fb_we_d    = 1'b1;
                fb_addr_d  = sweep_q;
                fb_wdata_d = CLEAR_COLOR;
                sweep_d    = sweep_q + ADDR_W'(1);
            end
        end else begin
            if (pop) begin
                if (on_screen) begin
                    fb_we_d    = 1'b1;
                    fb_addr_d  = prod[ADDR_W-1:0];
                    fb_wdata_d = head.color;
                end else begin
                    fb_we_d = 1'b0;
                    if (clip_cnt_q != 16'hFFFF) begin
                        clip_cnt_d = clip_cnt_q + 16'd1;
                    end
                end
            end else if (consumed) begin
                fb_we_d = 1'b0;
            end

            if ((state_q == S_RUN) && sink_io.clear_req) begin
                state_d      = S_FLUSH;
                clear_busy_d = 1'b1;
            end else if ((state_q == S_FLUSH) && fifo_empty && out_free) begin
                state_d = S_CLEAR;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            state_q      <= S_RUN;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_wdata_q   <= '0;
            sweep_q      <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            clip_cnt_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            state_q      <= state_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            sweep_q      <= sweep_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
            clip_cnt_q   <= clip_cnt_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= '{x: sink_io.pix_x, y: sink_io.pix_y, color: sink_io.pix_color};
        end
    end

    assign sink_io.pix_ready  = pix_ready;
    assign sink_io.fb_we      = fb_we_q;
    assign sink_io.fb_addr    = fb_addr_q;
    assign sink_io.fb_wdata   = fb_wdata_q;
    assign sink_io.clear_busy = clear_busy_q;
    assign sink_io.clear_done = clear_done_q;
    assign sink_io.clip_cnt   = clip_cnt_q;

endmodule

// File: tb/tb_pixel_sink.sv
// Directed bench for pixel_sink on a 40x30 screen so full clear sweeps stay short.
module tb_pixel_sink;
    localparam int W = 40;
    localparam int H = 30;
    localparam int N = W * H;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pixel_sink_if #(.COLOR_W(1), .ADDR_W(19)) bus ();

    pixel_sink #(
        .WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(8), .ADDR_W(19), .COLOR_W(1), .CLEAR_COLOR(1'b0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sink_io (bus)
    );

    int total = 0;
    int bad   = 0;

    // Write log: a write is completed at the edge following a negedge where fb_we & ~fb_stall.
    int wr_addr_q[$];
    int wr_data_q[$];
    int done_cnt = 0;

    always @(negedge clk) begin
        if (bus.fb_we && !bus.fb_stall) begin
            wr_addr_q.push_back(int'(bus.fb_addr));
            wr_data_q.push_back(int'(bus.fb_wdata));
        end
        if (bus.clear_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pix(input int x, input int y, input int c);
        bus.pix_valid = 1'b1;
        bus.pix_x     = 11'(x);
        bus.pix_y     = 11'(y);
        bus.pix_color = 1'(c);
    endtask

    initial begin
        int errs;
        int found;
        int hold_err;
        int stall_done;
        int req2_done;
        int we_err;

        bus.pix_valid = 1'b0;
        bus.pix_x     = '0;
        bus.pix_y     = '0;
        bus.pix_color = '0;
        bus.clear_req = 1'b0;
        bus.fb_stall  = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_pix_ready", bus.pix_ready, 0);
        chk("rst_fb_we", bus.fb_we, 0);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_fb_wdata", bus.fb_wdata, 0);
        chk("rst_clear_busy", bus.clear_busy, 0);
        chk("rst_clear_done", bus.clear_done, 0);
        chk("rst_clip_cnt", bus.clip_cnt, 0);
        reset = 1'b1;
        step();
        chk("post_rst_ready", bus.pix_ready, 1);

        // Single pixel (3,2) -> 2*40+3 = 83, written after edge k+1
        wr_addr_q.delete(); wr_data_q.delete();
        drive_pix(3, 2, 1);
        step();
        bus.pix_valid = 1'b0;
        chk("t1_we_edge_k", bus.fb_we, 0);
        step();
        chk("t1_we_edge_k1", bus.fb_we, 1);
        chk("t1_addr", bus.fb_addr, 83);
        chk("t1_wdata", bus.fb_wdata, 1);
        step();
        chk("t1_we_after", bus.fb_we, 0);
        chk("t1_nwrites", wr_addr_q.size(), 1);

        // Fill under stall: register absorbs one pixel, FIFO the next 8
        wr_addr_q.delete(); wr_data_q.delete();
        bus.fb_stall = 1'b1;
        errs = 0;
        for (int i = 0; i < 9; i++) begin
            drive_pix(i, 1, i & 1);
            if (bus.pix_ready !== 1'b1) errs++;
            step();
        end
        chk("t2_ready_while_filling", errs, 0);
        drive_pix(30, 3, 1);
        chk("t2_ready_full", bus.pix_ready, 0);
        step();
        step();
        chk("t2_ready_full_held", bus.pix_ready, 0);
        bus.pix_valid = 1'b0;
        chk("t2_we_stalled", bus.fb_we, 1);
        chk("t2_addr_stalled", bus.fb_addr, 40);
        chk("t2_no_write_stalled", wr_addr_q.size(), 0);
        bus.fb_stall = 1'b0;
        repeat (9) step();
        chk("t2_nwrites", wr_addr_q.size(), 9);
        chk("t2_we_drained", bus.fb_we, 0);
        errs = 0;
        for (int i = 0; i < 9 && i < wr_addr_q.size(); i++) begin
            if (wr_addr_q[i] != 40 + i || wr_data_q[i] != (i & 1)) errs++;
        end
        chk("t2_order", errs, 0);

        // Clipping, including an 11-bit x far beyond the screen
        wr_addr_q.delete(); wr_data_q.delete();
        drive_pix(W, 0, 1);       step();
        drive_pix(0, H, 1);       step();
        drive_pix(W-1, H-1, 1);   step();
        drive_pix(2047, 5, 1);    step();
        bus.pix_valid = 1'b0;
        repeat (4) step();
        chk("t3_nwrites", wr_addr_q.size(), 1);
        if (wr_addr_q.size() > 0) chk("t3_addr", wr_addr_q[0], N - 1);
        chk("t3_clip_cnt", bus.clip_cnt, 3);

        // Flush then full sweep, with stall at 100 and an ignored second clear_req
        wr_addr_q.delete(); wr_data_q.delete();
        drive_pix(1, 0, 1); step();
        drive_pix(2, 0, 1); step();
        drive_pix(3, 0, 1);
        bus.clear_req = 1'b1;
        step();
        bus.pix_valid = 1'b0;
        bus.clear_req = 1'b0;
        chk("t4_busy", bus.clear_busy, 1);
        chk("t4_ready_busy", bus.pix_ready, 0);
        found = 0; hold_err = 0; stall_done = 0; req2_done = 0;
        for (int c = 0; c < 3000 && found == 0; c++) begin
            step();
            if (bus.clear_req) bus.clear_req = 1'b0;
            if (bus.clear_done) begin
                found = 1;
            end else if (!stall_done && bus.fb_we && bus.fb_addr == 100) begin
                bus.fb_stall = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    step();
                    if (bus.fb_we !== 1'b1 || bus.fb_addr !== 19'd100) hold_err++;
                end
                bus.fb_stall = 1'b0;
                stall_done = 1;
            end else if (!req2_done && bus.fb_we && bus.fb_addr == 300) begin
                bus.clear_req = 1'b1;
                req2_done = 1;
            end
        end
        chk("t4_clear_done_seen", found, 1);
        chk("t5_stall_seen", stall_done, 1);
        chk("t5_addr_held", hold_err, 0);
        chk("t4_busy_at_done", bus.clear_busy, 0);
        chk("t4_ready_at_done", bus.pix_ready, 1);
        step();
        chk("t4_done_pulse", bus.clear_done, 0);
        repeat (5) step();
        chk("t5_second_req_ignored", bus.clear_busy, 0);
        chk("t4_nwrites", wr_addr_q.size(), N + 3);
        errs = 0;
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            if (i < 3) begin
                if (wr_addr_q[i] != i + 1 || wr_data_q[i] != 1) errs++;
            end else begin
                if (wr_addr_q[i] != i - 3 || wr_data_q[i] != 0) errs++;
            end
        end
        chk("t4_sweep_seq", errs, 0);
        chk("t4_done_count", done_cnt, 1);

        // Reset in the middle of a sweep
        bus.clear_req = 1'b1;
        step();
        bus.clear_req = 1'b0;
        found = 0;
        for (int c = 0; c < 2000 && found == 0; c++) begin
            step();
            if (bus.fb_we && bus.fb_addr == 500) found = 1;
        end
        chk("t6_reached_500", found, 1);
        reset = 1'b0;
        step();
        chk("t6_we", bus.fb_we, 0);
        chk("t6_busy", bus.clear_busy, 0);
        chk("t6_clip", bus.clip_cnt, 0);
        chk("t6_done", bus.clear_done, 0);
        chk("t6_ready_in_rst", bus.pix_ready, 0);
        reset = 1'b1;
        step();
        chk("t6_ready_after", bus.pix_ready, 1);
        we_err = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.fb_we !== 1'b0 || bus.clear_done !== 1'b0) we_err++;
        end
        chk("t6_sweep_aborted", we_err, 0);
        chk("t6_no_done", done_cnt, 1);
        drive_pix(W-1, 0, 1);
        step();
        bus.pix_valid = 1'b0;
        step();
        chk("t6_post_we", bus.fb_we, 1);
        chk("t6_post_addr", bus.fb_addr, W - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
